// File: rtl/write_back_phase.sv
// rtl/write_back_phase.sv - write-back stage: register file, load tracking, bypass, load-use stall
module write_back_phase #(
    parameter int REG_N        = 17,
    parameter int REG_W        = 64,
    parameter int EFL_ADDR     = 16,
    parameter int RCX_ADDR     = 1,
    parameter int LOAD_LATENCY = 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             wb_valid,
    input  logic             wb_is_load,
    input  logic [4:0]       wb_dst,
    input  logic [1:0]       wb_bmd,
    input  logic [REG_W-1:0] wb_data,
    input  logic [2:0]       wb_ld_offset,
    input  logic [REG_W-1:0] ld_data,
    input  logic             eflags_update,
    input  logic [REG_W-1:0] eflags_in,
    input  logic             rd_en_s,
    input  logic [4:0]       rd_addr_s,
    input  logic             rd_en_t,
    input  logic [4:0]       rd_addr_t,
    output logic [REG_W-1:0] rd_data_s,
    output logic [REG_W-1:0] rd_data_t,
    output logic [REG_W-1:0] efl_out,
    output logic [REG_W-1:0] rcx_out,
    output logic             stall
);

    localparam int LR = LOAD_LATENCY - 1;

    logic [REG_W-1:0] regs [REG_N];

    logic             q_vld [LOAD_LATENCY];
    logic [4:0]       q_dst [LOAD_LATENCY];
    logic [1:0]       q_bmd [LOAD_LATENCY];
    logic [2:0]       q_off [LOAD_LATENCY];

    logic             alu_we;
    logic             ld_we;
    logic [4:0]       ld_dst;
    logic [REG_W-1:0] alu_old;
    logic [REG_W-1:0] ld_old;
    logic [REG_W-1:0] alu_val;
    logic [REG_W-1:0] ld_val;
    logic [REG_W-1:0] ld_aligned;
    logic             stall_v;

    function automatic logic in_range(input logic [4:0] a);
        return int'(a) < REG_N;
    endfunction

    function automatic logic [REG_W-1:0] merge(input logic [REG_W-1:0] old_v,
                                               input logic [REG_W-1:0] v,
                                               input logic [1:0]       bmd);
        case (bmd)
            2'd0:    return {old_v[REG_W-1:8], v[7:0]};
            2'd1:    return {{(REG_W-32){1'b0}}, v[31:0]};
            default: return v;
        endcase
    endfunction

    // Youngest writer wins: ALU commit, then returning load, then EFLAGS update.
    function automatic logic [REG_W-1:0] src_read(input logic en, input logic [4:0] a);
        if (!en)                                               return '0;
        if (alu_we && a == wb_dst)                             return alu_val;
        if (ld_we && a == ld_dst)                              return ld_val;
        if (rstn && eflags_update && int'(a) == EFL_ADDR)      return eflags_in;
        if (in_range(a))                                       return regs[a];
        return '0;
    endfunction

    assign ld_dst     = q_dst[LR];
    assign alu_we     = rstn & wb_valid & ~wb_is_load & in_range(wb_dst);
    assign ld_we      = rstn & q_vld[LR] & in_range(ld_dst);
    assign alu_old    = in_range(wb_dst) ? regs[wb_dst] : '0;
    assign ld_old     = in_range(ld_dst) ? regs[ld_dst] : '0;
    assign ld_aligned = ld_data >> {q_off[LR], 3'b000};
    assign alu_val    = merge(alu_old, wb_data, wb_bmd);
    assign ld_val     = merge(ld_old, ld_aligned, q_bmd[LR]);

    always_comb begin
        rd_data_s = src_read(rd_en_s, rd_addr_s);
        rd_data_t = src_read(rd_en_t, rd_addr_t);
    end

    // The returning entry is bypassed, so only younger in-flight loads stall.
    always_comb begin
        stall_v = 1'b0;
        if (wb_valid && wb_is_load && in_range(wb_dst)) begin
            if (rd_en_s && rd_addr_s == wb_dst) stall_v = 1'b1;
            if (rd_en_t && rd_addr_t == wb_dst) stall_v = 1'b1;
        end
        for (int i = 0; i < LOAD_LATENCY - 1; i++) begin
            if (q_vld[i] && in_range(q_dst[i])) begin
                if (rd_en_s && rd_addr_s == q_dst[i]) stall_v = 1'b1;
                if (rd_en_t && rd_addr_t == q_dst[i]) stall_v = 1'b1;
            end
        end
        stall = rstn & stall_v;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < REG_N; i++) regs[i] <= '0;
        end else begin
            for (int i = 0; i < REG_N; i++) begin
                if (alu_we && int'(wb_dst) == i)              regs[i] <= alu_val;
                else if (ld_we && int'(ld_dst) == i)          regs[i] <= ld_val;
                else if (eflags_update && i == EFL_ADDR)      regs[i] <= eflags_in;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < LOAD_LATENCY; i++) begin
                q_vld[i] <= 1'b0;
                q_dst[i] <= '0;
                q_bmd[i] <= '0;
                q_off[i] <= '0;
            end
        end else begin
            q_vld[0] <= wb_valid & wb_is_load;
            q_dst[0] <= wb_dst;
            q_bmd[0] <= wb_bmd;
            q_off[0] <= wb_ld_offset;
            for (int i = 1; i < LOAD_LATENCY; i++) begin
                q_vld[i] <= q_vld[i-1];
                q_dst[i] <= q_dst[i-1];
                q_bmd[i] <= q_bmd[i-1];
                q_off[i] <= q_off[i-1];
            end
        end
    end

    assign efl_out = regs[EFL_ADDR];
    assign rcx_out = regs[RCX_ADDR];

endmodule

// File: tb/tb_write_back_phase.sv
// tb/tb_write_back_phase.sv - bench for write_back_phase at load latencies 1 and 3
module tb_write_back_phase;

    logic        clk;
    logic        rstn;
    logic        wb_valid, wb_is_load, eflags_update;
    logic [4:0]  wb_dst;
    logic [1:0]  wb_bmd;
    logic [2:0]  wb_ld_offset;
    logic [63:0] wb_data, ld_data, eflags_in;
    logic        rd_en_s, rd_en_t;
    logic [4:0]  rd_addr_s, rd_addr_t;
    logic [63:0] rd_s0, rd_t0, efl0, rcx0, rd_s1, rd_t1, efl1, rcx1;
    logic        stall0, stall1;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit armed  = 0;

    typedef struct {
        int         d;
        int         due;
        logic [4:0] dst;
        logic [1:0] bmd;
        logic [2:0] off;
    } ld_t;

    ld_t         pq[$];
    logic [63:0] m [2][17];

    write_back_phase u0 (
        .clk(clk), .rstn(rstn), .wb_valid(wb_valid), .wb_is_load(wb_is_load),
        .wb_dst(wb_dst), .wb_bmd(wb_bmd), .wb_data(wb_data), .wb_ld_offset(wb_ld_offset),
        .ld_data(ld_data), .eflags_update(eflags_update), .eflags_in(eflags_in),
        .rd_en_s(rd_en_s), .rd_addr_s(rd_addr_s), .rd_en_t(rd_en_t), .rd_addr_t(rd_addr_t),
        .rd_data_s(rd_s0), .rd_data_t(rd_t0), .efl_out(efl0), .rcx_out(rcx0), .stall(stall0)
    );

    write_back_phase #(.LOAD_LATENCY(3)) u1 (
        .clk(clk), .rstn(rstn), .wb_valid(wb_valid), .wb_is_load(wb_is_load),
        .wb_dst(wb_dst), .wb_bmd(wb_bmd), .wb_data(wb_data), .wb_ld_offset(wb_ld_offset),
        .ld_data(ld_data), .eflags_update(eflags_update), .eflags_in(eflags_in),
        .rd_en_s(rd_en_s), .rd_addr_s(rd_addr_s), .rd_en_t(rd_en_t), .rd_addr_t(rd_addr_t),
        .rd_data_s(rd_s1), .rd_data_t(rd_t1), .efl_out(efl1), .rcx_out(rcx1), .stall(stall1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int lat(int d);
        return (d == 0) ? 1 : 3;
    endfunction

    function automatic logic [63:0] mrg(logic [63:0] old_v, logic [63:0] v, logic [1:0] bmd);
        if (bmd == 2'd0) return (old_v & ~64'hFF) | (v & 64'hFF);
        if (bmd == 2'd1) return v & 64'hFFFF_FFFF;
        return v;
    endfunction

    function automatic int ret_idx(int d);
        for (int i = 0; i < pq.size(); i++)
            if (pq[i].d == d && pq[i].due == cyc) return i;
        return -1;
    endfunction

    function automatic logic [63:0] exp_rd(int d, logic en, logic [4:0] a);
        int r;
        if (!en) return 64'd0;
        r = ret_idx(d);
        if (wb_valid && !wb_is_load && a == wb_dst && a < 17)
            return mrg(m[d][a], wb_data, wb_bmd);
        if (r >= 0 && pq[r].dst == a && a < 17)
            return mrg(m[d][a], ld_data >> (8 * pq[r].off), pq[r].bmd);
        if (eflags_update && a == 16) return eflags_in;
        if (a < 17) return m[d][a];
        return 64'd0;
    endfunction

    function automatic logic port_hits(logic [4:0] a);
        return (rd_en_s && rd_addr_s == a) || (rd_en_t && rd_addr_t == a);
    endfunction

    function automatic logic exp_stall(int d);
        if (!rstn) return 1'b0;
        if (wb_valid && wb_is_load && wb_dst < 17 && port_hits(wb_dst)) return 1'b1;
        for (int i = 0; i < pq.size(); i++)
            if (pq[i].d == d && pq[i].due > cyc && pq[i].dst < 17 && port_hits(pq[i].dst))
                return 1'b1;
        return 1'b0;
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic sample();
        @(negedge clk);
        if (armed) begin
            for (int d = 0; d < 2; d++) begin
                if (rstn) begin
                    chk($sformatf("rd_s[%0d]", d), d ? rd_s1 : rd_s0, exp_rd(d, rd_en_s, rd_addr_s));
                    chk($sformatf("rd_t[%0d]", d), d ? rd_t1 : rd_t0, exp_rd(d, rd_en_t, rd_addr_t));
                end
                chk($sformatf("stall[%0d]", d), {63'd0, d ? stall1 : stall0}, {63'd0, exp_stall(d)});
                chk($sformatf("efl[%0d]", d), d ? efl1 : efl0, m[d][16]);
                chk($sformatf("rcx[%0d]", d), d ? rcx1 : rcx0, m[d][1]);
            end
        end
    endtask

    task automatic tick();
        logic [63:0] nm [17];
        int r;
        @(posedge clk);
        if (!rstn) begin
            for (int d = 0; d < 2; d++)
                for (int i = 0; i < 17; i++) m[d][i] = 64'd0;
            pq.delete();
        end else begin
            for (int d = 0; d < 2; d++) begin
                r = ret_idx(d);
                for (int i = 0; i < 17; i++) nm[i] = m[d][i];
                if (eflags_update) nm[16] = eflags_in;
                if (r >= 0 && pq[r].dst < 17)
                    nm[pq[r].dst] = mrg(m[d][pq[r].dst], ld_data >> (8 * pq[r].off), pq[r].bmd);
                if (wb_valid && !wb_is_load && wb_dst < 17)
                    nm[wb_dst] = mrg(m[d][wb_dst], wb_data, wb_bmd);
                for (int i = 0; i < 17; i++) m[d][i] = nm[i];
            end
            for (int i = pq.size() - 1; i >= 0; i--)
                if (pq[i].due <= cyc) pq.delete(i);
            if (wb_valid && wb_is_load)
                for (int d = 0; d < 2; d++)
                    pq.push_back('{d: d, due: cyc + lat(d), dst: wb_dst, bmd: wb_bmd, off: wb_ld_offset});
        end
        cyc++;
        #1;
    endtask

    task automatic idle();
        wb_valid = 0; wb_is_load = 0; wb_dst = 0; wb_bmd = 0; wb_data = 0; wb_ld_offset = 0;
        eflags_update = 0; eflags_in = 0; rd_en_s = 0; rd_addr_s = 0; rd_en_t = 0; rd_addr_t = 0;
    endtask

    task automatic alu(logic [4:0] dst, logic [1:0] bmd, logic [63:0] data);
        wb_valid = 1; wb_is_load = 0; wb_dst = dst; wb_bmd = bmd; wb_data = data;
    endtask

    task automatic load(logic [4:0] dst, logic [1:0] bmd, logic [2:0] off);
        wb_valid = 1; wb_is_load = 1; wb_dst = dst; wb_bmd = bmd; wb_ld_offset = off;
        wb_data = {$urandom, $urandom};
    endtask

    initial begin
        idle();
        ld_data = 64'd0;
        rstn = 0;
        tick();
        rstn = 1;
        armed = 1;

        // reset state
        rd_en_s = 1; rd_addr_s = 5'd3; rd_en_t = 1; rd_addr_t = 5'd16;
        sample();
        chk("reset_rd", rd_s0, 64'd0);
        chk("reset_stall", {63'd0, stall0}, 64'd0);
        chk("reset_efl", efl0, 64'd0);
        tick();

        // width merges
        idle(); alu(5'd3, 2'd2, 64'h1122_3344_5566_7788); sample(); tick();
        idle(); alu(5'd3, 2'd0, 64'hFFFF_FFFF_FFFF_FFAB); sample(); tick();
        idle(); rd_en_s = 1; rd_addr_s = 5'd3; sample();
        chk("merge8", rd_s0, 64'h1122_3344_5566_77AB); tick();
        idle(); alu(5'd3, 2'd1, 64'hFFFF_FFFF_DEAD_BEEF); sample(); tick();
        idle(); rd_en_s = 1; rd_addr_s = 5'd3; sample();
        chk("merge32", rd_s0, 64'h0000_0000_DEAD_BEEF); tick();

        // load-use stall and returning-load bypass
        idle(); load(5'd5, 2'd1, 3'd2); rd_en_s = 1; rd_addr_s = 5'd5; sample();
        chk("load_use_stall", {63'd0, stall0}, 64'd1); tick();
        idle(); ld_data = 64'h0000_CAFE_BABE_0000; rd_en_s = 1; rd_addr_s = 5'd5; sample();
        chk("load_bypass", rd_s0, 64'h0000_0000_CAFE_BABE); tick();
        idle(); rd_en_t = 1; rd_addr_t = 5'd5; sample();
        chk("load_commit", rd_t0, 64'h0000_0000_CAFE_BABE); tick();

        // ALU beats returning load to same register
        idle(); load(5'd7, 2'd2, 3'd0); sample(); tick();
        idle(); alu(5'd7, 2'd2, 64'h55); ld_data = {$urandom, $urandom};
        rd_en_s = 1; rd_addr_s = 5'd7; sample();
        chk("alu_over_load_bypass", rd_s0, 64'h55); tick();
        idle(); rd_en_s = 1; rd_addr_s = 5'd7; sample();
        chk("alu_over_load_commit", rd_s0, 64'h55); tick();

        // EFLAGS update and ALU override
        idle(); eflags_update = 1; eflags_in = 64'h246; sample(); tick();
        idle(); sample(); chk("efl_update", efl0, 64'h246); tick();
        idle(); eflags_update = 1; eflags_in = 64'h999; alu(5'd16, 2'd2, 64'h2); sample(); tick();
        idle(); sample(); chk("efl_alu_wins", efl0, 64'h2); tick();

        // reset while a latency-3 load is in flight
        idle(); load(5'd2, 2'd2, 3'd0); sample(); tick();
        idle(); sample(); tick();
        rstn = 0; sample(); tick();
        rstn = 1;
        for (int k = 0; k < 4; k++) begin
            idle(); ld_data = {$urandom, $urandom} | 64'h1; rd_en_s = 1; rd_addr_s = 5'd2;
            sample();
            chk("reset_drops_load", rd_s1, 64'd0);
            chk("reset_drops_stall", {63'd0, stall1}, 64'd0);
            tick();
        end

        // randomized traffic
        for (int k = 0; k < 500; k++) begin
            rstn          = ($urandom % 60) != 0;
            wb_valid      = ($urandom % 4) != 0;
            wb_is_load    = ($urandom % 3) == 0;
            wb_dst        = 5'($urandom_range(0, 19));
            wb_bmd        = 2'($urandom);
            wb_data       = {$urandom, $urandom};
            wb_ld_offset  = 3'($urandom);
            ld_data       = {$urandom, $urandom};
            eflags_update = ($urandom % 4) == 0;
            eflags_in     = {$urandom, $urandom};
            rd_en_s       = ($urandom % 4) != 0;
            rd_addr_s     = 5'($urandom_range(0, 18));
            rd_en_t       = ($urandom % 4) != 0;
            rd_addr_t     = 5'($urandom_range(0, 18));
            sample();
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
